// File: rtl/rx_pkt_scheduler.sv
// Packet scheduler for the rx channel/command FIFOs: picks one eligible source,
// starts the packet builder, and holds the selection until pkt_done or watchdog abort.
module rx_pkt_scheduler #(
    parameter int NUM_CHAN = 1,
    parameter int CMD_PRIO = 1,
    parameter int TIMEOUT  = 1023
) (
    input  logic              rxclk,
    input  logic              reset,
    input  logic [NUM_CHAN:0] chan_empty,
    input  logic [NUM_CHAN:0] chan_enable,
    input  logic              have_space,
    input  logic              pkt_done,
    input  logic              clear_status,
    output logic [3:0]        rd_select,
    output logic              start,
    output logic              busy,
    output logic [15:0]       grant_count,
    output logic              timeout_err
);

    localparam int         NUM_SRC = NUM_CHAN + 1;
    localparam logic [3:0] CMD_IDX = 4'(NUM_CHAN);
    localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_HOLDOFF   = 2'd3
    } state_t;

    state_t      state_q;
    logic [3:0]  rd_select_q;
    logic [3:0]  last_q;
    logic        start_q;
    logic        busy_q;
    logic        timeout_err_q;
    logic [15:0] grant_count_q;
    logic [9:0]  wd_cnt_q;

    logic [15:0] elig_s;
    logic [15:0] scan_s;
    logic [3:0]  win_s;
    logic        win_valid_s;
    logic        upd_last_s;
    logic [4:0]  idx_s;

    // Winner selection: command priority override, else round-robin after last_q.
    always_comb begin
        elig_s      = 16'(chan_enable & ~chan_empty);
        scan_s      = elig_s;
        win_s       = 4'd0;
        win_valid_s = 1'b0;
        upd_last_s  = 1'b0;
        idx_s       = 5'd0;
        if (CMD_PRIO != 0) begin
            scan_s[CMD_IDX] = 1'b0;
        end else begin
            scan_s = elig_s;
        end
        if ((CMD_PRIO != 0) && elig_s[CMD_IDX]) begin
            win_s       = CMD_IDX;
            win_valid_s = 1'b1;
        end else begin
            // Scan farthest-first so the nearest eligible index overwrites the result.
            for (int k = NUM_SRC; k >= 1; k--) begin
                idx_s = {1'b0, last_q} + 5'(k);
                if (idx_s >= 5'(NUM_SRC)) begin
                    idx_s = idx_s - 5'(NUM_SRC);
                end else begin
                    idx_s = idx_s;
                end
                if (scan_s[idx_s[3:0]]) begin
                    win_s       = idx_s[3:0];
                    win_valid_s = 1'b1;
                    upd_last_s  = 1'b1;
                end else begin
                    win_s = win_s;
                end
            end
        end
    end

    // Scheduler FSM with registered outputs and watchdog.
    always_ff @(posedge rxclk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rd_select_q   <= 4'd0;
            last_q        <= CMD_IDX;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            grant_count_q <= 16'd0;
            wd_cnt_q      <= 10'd0;
        end else begin
            start_q <= 1'b0;
            // A set later in this block overrides the clear.
            if (clear_status) begin
                timeout_err_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (have_space && win_valid_s) begin
                        rd_select_q <= win_s;
                        if (upd_last_s) begin
                            last_q <= win_s;
                        end
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    grant_count_q <= grant_count_q + 16'd1;
                    wd_cnt_q      <= 10'd0;
                    state_q       <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (pkt_done) begin
                        state_q <= ST_HOLDOFF;
                    end else if (wd_cnt_q == WD_LAST) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= ST_HOLDOFF;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 10'd1;
                    end
                end
                ST_HOLDOFF: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_select   = rd_select_q;
    assign start       = start_q;
    assign busy        = busy_q;
    assign grant_count = grant_count_q;
    assign timeout_err = timeout_err_q;

endmodule
